// File: rtl/ib_pkg.sv
// Shared types and defaults for the UART <-> meter byte bridge.
package ib_pkg;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 16000;

  typedef enum logic [1:0] {
    D_IDLE,
    D_OFFER,
    D_RELEASE
  } down_state_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_CAPTURE,
    U_SEND,
    U_ACK
  } up_state_t;

endpackage

// File: rtl/ib_byte_fifo.sv
// Byte FIFO between the UART receiver and the meter handshake.
// A push while full is accepted only when a pop happens in the same cycle.
module ib_byte_fifo
  import ib_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ib_link_ctrl.sv
// Bridges UART bytes to/from a meter behind an IO expander using two
// independent four-phase handshakes, each guarded by a phase timeout.
//
// state     | meaning
// D_IDLE    | waiting for a queued UART byte
// D_OFFER   | byte offered to meter, waiting for ack_n low
// D_RELEASE | offer withdrawn, waiting for ack_n high, then pop
// U_IDLE    | waiting for meter rx_data_available
// U_CAPTURE | sampling rx_data one cycle after availability seen
// U_SEND    | byte presented to UART until ready
// U_ACK     | tx_ack high until meter drops rx_data_available
module ib_link_ctrl
  import ib_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_valid,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_available,
  input  logic       tx_data_ack_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_available,
  output logic       tx_ack,
  input  logic       err_clr,
  output logic       overflow,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]  ack_n_sync_q, ack_n_sync_d;
  logic [1:0]  rx_av_sync_q, rx_av_sync_d;
  logic        ack_n_s, rx_av_s;

  down_state_t down_state_q, down_state_d;
  up_state_t   up_state_q, up_state_d;
  logic [CW-1:0] down_cnt_q, down_cnt_d;
  logic [CW-1:0] up_cnt_q, up_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  uart_tx_data_q, uart_tx_data_d;
  logic        overflow_q, overflow_d;
  logic        timeout_q, timeout_d;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        down_tmo_evt, up_tmo_evt;

  // Meter-side signals are asynchronous; nothing downstream sees them raw.
  assign ack_n_sync_d = {ack_n_sync_q[0], tx_data_ack_n};
  assign rx_av_sync_d = {rx_av_sync_q[0], rx_data_available};
  assign ack_n_s      = ack_n_sync_q[1];
  assign rx_av_s      = rx_av_sync_q[1];

  ib_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (uart_rx_valid),
    .pop   (fifo_pop),
    .wdata (uart_rx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    down_state_d = down_state_q;
    down_cnt_d   = down_cnt_q;
    tx_data_d    = tx_data_q;
    fifo_pop     = 1'b0;
    down_tmo_evt = 1'b0;
    case (down_state_q)
      D_IDLE: begin
        if (!fifo_empty) begin
          down_state_d = D_OFFER;
          tx_data_d    = fifo_rdata;
        end
      end
      D_OFFER: begin
        if (!ack_n_s) begin
          down_state_d = D_RELEASE;
        end else if (down_cnt_q == CNT_LAST) begin
          down_tmo_evt = 1'b1;
          fifo_pop     = 1'b1;
          down_state_d = D_IDLE;
        end
      end
      D_RELEASE: begin
        if (ack_n_s) begin
          fifo_pop     = 1'b1;
          down_state_d = D_IDLE;
        end else if (down_cnt_q == CNT_LAST) begin
          down_tmo_evt = 1'b1;
          fifo_pop     = 1'b1;
          down_state_d = D_IDLE;
        end
      end
      default: down_state_d = D_IDLE;
    endcase
    if (down_state_d != down_state_q) begin
      down_cnt_d = '0;
    end else if (down_state_q == D_OFFER || down_state_q == D_RELEASE) begin
      down_cnt_d = down_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    up_state_d     = up_state_q;
    up_cnt_d       = up_cnt_q;
    uart_tx_data_d = uart_tx_data_q;
    up_tmo_evt     = 1'b0;
    case (up_state_q)
      U_IDLE: begin
        if (rx_av_s) up_state_d = U_CAPTURE;
      end
      U_CAPTURE: begin
        uart_tx_data_d = rx_data;
        up_state_d     = U_SEND;
      end
      U_SEND: begin
        if (uart_tx_ready) up_state_d = U_ACK;
      end
      U_ACK: begin
        if (!rx_av_s) begin
          up_state_d = U_IDLE;
        end else if (up_cnt_q == CNT_LAST) begin
          up_tmo_evt = 1'b1;
          up_state_d = U_IDLE;
        end
      end
      default: up_state_d = U_IDLE;
    endcase
    if (up_state_d != up_state_q) begin
      up_cnt_d = '0;
    end else if (up_state_q == U_ACK) begin
      up_cnt_d = up_cnt_q + CNT_ONE;
    end
  end

  // Set events take priority over a same-cycle clear.
  always_comb begin
    overflow_d = err_clr ? 1'b0 : overflow_q;
    timeout_d  = err_clr ? 1'b0 : timeout_q;
    if (uart_rx_valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
    if (down_tmo_evt || up_tmo_evt)              timeout_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_n_sync_q   <= 2'b11;
      rx_av_sync_q   <= 2'b00;
      down_state_q   <= D_IDLE;
      up_state_q     <= U_IDLE;
      down_cnt_q     <= '0;
      up_cnt_q       <= '0;
      tx_data_q      <= '0;
      uart_tx_data_q <= '0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      ack_n_sync_q   <= ack_n_sync_d;
      rx_av_sync_q   <= rx_av_sync_d;
      down_state_q   <= down_state_d;
      up_state_q     <= up_state_d;
      down_cnt_q     <= down_cnt_d;
      up_cnt_q       <= up_cnt_d;
      tx_data_q      <= tx_data_d;
      uart_tx_data_q <= uart_tx_data_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
    end
  end

  assign tx_data           = tx_data_q;
  assign tx_data_available = (down_state_q == D_OFFER);
  assign uart_tx_data      = uart_tx_data_q;
  assign uart_tx_valid     = (up_state_q == U_SEND);
  assign tx_ack            = (up_state_q == U_ACK);
  assign overflow          = overflow_q;
  assign timeout           = timeout_q;

endmodule

// File: tb/tb_ib_link_ctrl.sv
// Directed bench for ib_link_ctrl with a short phase timeout.
module tb_ib_link_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;
  logic [7:0] tx_data;
  logic       tx_data_available;
  logic       tx_data_ack_n;
  logic [7:0] rx_data;
  logic       rx_data_available;
  logic       tx_ack;
  logic       err_clr;
  logic       overflow;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  ib_link_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_tx_data      (uart_tx_data),
    .uart_tx_valid     (uart_tx_valid),
    .uart_tx_ready     (uart_tx_ready),
    .tx_data           (tx_data),
    .tx_data_available (tx_data_available),
    .tx_data_ack_n     (tx_data_ack_n),
    .rx_data           (rx_data),
    .rx_data_available (rx_data_available),
    .tx_ack            (tx_ack),
    .err_clr           (err_clr),
    .overflow          (overflow),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return tx_data_available;
      1:       return uart_tx_valid;
      2:       return tx_ack;
      default: return timeout;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic lvl, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sig(which) == lvl) break;
      cyc();
    end
    chk(tag, {31'd0, sig(which)}, {31'd0, lvl});
  endtask

  task automatic uart_send(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  task automatic meter_accept(input logic [7:0] exp);
    wait_for("offer_rise", 0, 1'b1, 20);
    chk("offer_data", {24'd0, tx_data}, {24'd0, exp});
    repeat (2) cyc();
    chk("offer_hold_data", {24'd0, tx_data}, {24'd0, exp});
    chk("offer_hold_avail", {31'd0, tx_data_available}, 32'd1);
    tx_data_ack_n = 1'b0;
    wait_for("offer_fall", 0, 1'b0, 10);
    tx_data_ack_n = 1'b1;
  endtask

  task automatic host_recv(input logic [7:0] b, input int stall);
    rx_data           = b;
    rx_data_available = 1'b1;
    wait_for("up_valid_rise", 1, 1'b1, 10);
    chk("up_data", {24'd0, uart_tx_data}, {24'd0, b});
    for (int i = 0; i < stall; i++) begin
      cyc();
      chk("up_valid_held", {31'd0, uart_tx_valid}, 32'd1);
      chk("up_ack_early", {31'd0, tx_ack}, 32'd0);
    end
    chk("up_data_held", {24'd0, uart_tx_data}, {24'd0, b});
    uart_tx_ready = 1'b1;
    cyc();
    uart_tx_ready = 1'b0;
    chk("up_ack_rise", {31'd0, tx_ack}, 32'd1);
    chk("up_valid_drop", {31'd0, uart_tx_valid}, 32'd0);
    rx_data_available = 1'b0;
    cyc();
    chk("up_ack_hold", {31'd0, tx_ack}, 32'd1);
    wait_for("up_ack_fall", 2, 1'b0, 6);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_tx_avail"}, {31'd0, tx_data_available}, 32'd0);
    chk({tag, "_tx_ack"}, {31'd0, tx_ack}, 32'd0);
    chk({tag, "_uvalid"}, {31'd0, uart_tx_valid}, 32'd0);
    chk({tag, "_udata"}, {24'd0, uart_tx_data}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst              = 1'b0;
    uart_rx_data      = 8'h00;
    uart_rx_valid     = 1'b0;
    uart_tx_ready     = 1'b0;
    tx_data_ack_n     = 1'b1;
    rx_data           = 8'h00;
    rx_data_available = 1'b0;
    err_clr           = 1'b0;
    repeat (3) cyc();
    chk_all_reset("rst");
    nrst = 1'b1;
    repeat (3) cyc();
    chk_all_reset("post_rst");

    // Two bytes through the downstream handshake.
    uart_send(8'h41);
    uart_send(8'h42);
    meter_accept(8'h41);
    meter_accept(8'h42);
    chk("dn_ovf_clean", {31'd0, overflow}, 32'd0);

    // Stalled meter: five pushes, four kept.
    uart_send(8'h01);
    uart_send(8'h02);
    uart_send(8'h03);
    uart_send(8'h04);
    uart_send(8'h05);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    pulse_clr();
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    uart_rx_data  = 8'h06;
    uart_rx_valid = 1'b1;
    err_clr       = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    err_clr       = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    pulse_clr();
    chk("ovf_clr2", {31'd0, overflow}, 32'd0);
    meter_accept(8'h01);
    meter_accept(8'h02);
    meter_accept(8'h03);
    meter_accept(8'h04);
    repeat (10) cyc();
    chk("fifo_drained", {31'd0, tx_data_available}, 32'd0);
    chk("drain_tmo_clean", {31'd0, timeout}, 32'd0);

    // Upstream with UART back-pressure.
    host_recv(8'h5A, 10);

    // Offer timeout discards the head byte.
    uart_send(8'h61);
    uart_send(8'h62);
    wait_for("tmo_offer_rise", 0, 1'b1, 10);
    chk("tmo_offer_data", {24'd0, tx_data}, 32'h61);
    repeat (TIMEOUT - 1) cyc();
    chk("tmo_not_yet", {31'd0, timeout}, 32'd0);
    chk("tmo_still_offer", {31'd0, tx_data_available}, 32'd1);
    cyc();
    chk("tmo_set", {31'd0, timeout}, 32'd1);
    chk("tmo_offer_drop", {31'd0, tx_data_available}, 32'd0);
    meter_accept(8'h62);
    pulse_clr();
    chk("tmo_clr", {31'd0, timeout}, 32'd0);

    // Reset in the middle of both handshakes.
    uart_send(8'h33);
    wait_for("rst_offer", 0, 1'b1, 10);
    rx_data           = 8'h44;
    rx_data_available = 1'b1;
    uart_tx_ready     = 1'b1;
    wait_for("rst_uack", 2, 1'b1, 10);
    uart_tx_ready     = 1'b0;
    chk("rst_still_offer", {31'd0, tx_data_available}, 32'd1);
    nrst = 1'b0;
    #1;
    chk_all_reset("mid_rst");
    rx_data_available = 1'b0;
    repeat (2) cyc();
    nrst = 1'b1;
    repeat (10) cyc();
    chk("rst_fifo_empty", {31'd0, tx_data_available}, 32'd0);
    chk("rst_up_idle", {31'd0, uart_tx_valid}, 32'd0);

    // Concurrent downstream and upstream transfers.
    uart_send(8'h10);
    fork
      meter_accept(8'h10);
      host_recv(8'h20, 0);
    join
    repeat (6) cyc();
    chk("conc_dn_idle", {31'd0, tx_data_available}, 32'd0);
    chk("conc_tmo", {31'd0, timeout}, 32'd0);
    chk("conc_ovf", {31'd0, overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ib_link_ctrl.md
IB_LINK_CTRL -- requirements
Module: ib_link_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: downstream FIFO entries, power of two.
REQ-002 Parameter TIMEOUT, default 16000: clk cycles allowed for each meter handshake phase (2 ms at 8 MHz).
REQ-003 clk  in  1  8 MHz system clock.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 uart_rx_data  in  8  byte received from the UART.
REQ-006 uart_rx_valid  in  1  one-cycle strobe; uart_rx_data valid.
REQ-007 uart_tx_data  out  8  byte to the UART transmitter.
REQ-008 uart_tx_valid  out  1  uart_tx_data valid; held until ready.
REQ-009 uart_tx_ready  in  1  UART accepts the byte when valid&ready.
REQ-010 tx_data  out  8  byte offered to the meter through the IO expander.
REQ-011 tx_data_available  out  1  high while a byte is offered to the meter.
REQ-012 tx_data_ack_n  in  1  meter acknowledge, active-low, asynchronous to clk.
REQ-013 rx_data  in  8  byte written by the meter, asynchronous to clk.
REQ-014 rx_data_available  in  1  meter byte pending, asynchronous to clk.
REQ-015 tx_ack  out  1  host has consumed rx_data.
REQ-016 err_clr  in  1  one-cycle strobe; clears the sticky error flags.
REQ-017 overflow  out  1  sticky: a UART byte was dropped because the FIFO was full.
REQ-018 timeout  out  1  sticky: a meter handshake phase exceeded TIMEOUT.

Function
REQ-019 tx_data_ack_n and rx_data_available shall pass through 2-flop synchronizers (reset value 1 and 0 respectively) before any use.
REQ-020 rx_data shall be sampled only in the cycle after synchronized rx_data_available is first seen high.
REQ-021 Downstream FIFO: push on uart_rx_valid; pop on leaving D_RELEASE; simultaneous push and pop when full shall be accepted without overflow.
REQ-022 A push to a full FIFO without a same-cycle pop shall drop the byte and set overflow.
REQ-023 Down FSM D_IDLE: FIFO non-empty -> D_OFFER; tx_data = FIFO head.
REQ-024 D_OFFER: tx_data_available=1, tx_data stable; synced ack_n low -> D_RELEASE.
REQ-025 D_RELEASE: tx_data_available=0; synced ack_n high -> pop -> D_IDLE.
REQ-026 Up FSM U_IDLE: synced rx_data_available high -> capture rx_data -> U_SEND.
REQ-027 U_SEND: uart_tx_valid=1 with the captured byte; uart_tx_ready -> U_ACK.
REQ-028 U_ACK: tx_ack=1; synced rx_data_available low -> tx_ack=0 -> U_IDLE.
REQ-029 Each FSM shall have its own phase counter, cleared on every state change; counting applies in D_OFFER, D_RELEASE and U_ACK only.
REQ-030 Counter reaching TIMEOUT in D_OFFER or D_RELEASE: set timeout, pop (discard) the byte, go to D_IDLE.
REQ-031 Counter reaching TIMEOUT in U_ACK: set timeout, drop tx_ack, go to U_IDLE.
REQ-032 U_SEND shall never time out.
REQ-033 err_clr shall clear both flags; a set event in the same cycle shall win.
REQ-034 The two FSMs shall run independently and concurrently.

Reset
REQ-035 On nrst low: FIFO empty; both FSMs in IDLE; counters 0; tx_data=0, tx_data_available=0, tx_ack=0, uart_tx_valid=0, uart_tx_data=0, overflow=0, timeout=0.
REQ-036 Reset asserted mid-handshake shall abort the handshake immediately; the in-flight byte is discarded.

Structure
REQ-037 Package ib_pkg shall hold the down_state_t and up_state_t enums and the default DEPTH and TIMEOUT constants.
REQ-038 The FIFO shall be a sub-module, ib_byte_fifo (DEPTH x 8, full/empty flags).

Verification
REQ-039 UART bytes 0x41, 0x42; meter acks each byte -> tx_data 0x41 then 0x42, each held through D_OFFER; overflow=0.
REQ-040 Five UART bytes while the meter is stalled -> four bytes queued, overflow=1; err_clr -> overflow=0.
REQ-041 Meter writes 0x5A with uart_tx_ready low for 10 cycles -> uart_tx_valid held with 0x5A; tx_ack rises only after ready; tx_ack falls after rx_data_available drops.
REQ-042 No meter ack for TIMEOUT cycles -> timeout=1, byte discarded, next FIFO byte offered.
REQ-043 nrst pulsed during D_OFFER and U_ACK -> all outputs at reset values within the same cycle; FIFO empty.
REQ-044 Downstream 0x10 and upstream 0x20 transfers overlapping -> both complete, no corruption.
